// File: rtl/efuse_ctrl.sv
// eFuse macro sequencer. After reset it loads every fuse bit into a shadow
// register and raises efuse_done. It then serves single-bit read and program
// commands, and every program is followed by a verify read.
// Each access runs three phases: address setup, strobe, then a one-cycle hold.
module efuse_ctrl #(
  parameter int EFUSE_BITS = 128,
  parameter int SETUP_CYC  = 2,
  parameter int RD_STB_CYC = 4,
  parameter int PG_STB_CYC = 200,
  parameter int LOCK_BIT   = 127
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_vld,
  input  logic                  cmd_mode,
  input  logic [6:0]            cmd_addr,
  input  logic                  pgm_en,
  input  logic                  op_done_clr,
  input  logic                  efuse_rdata,
  output logic [6:0]            efuse_addr,
  output logic                  efuse_rden,
  output logic                  efuse_pgm,
  output logic [EFUSE_BITS-1:0] efuse_data,
  output logic                  efuse_done,
  output logic                  efuse_rd,
  output logic                  efuse_wr,
  output logic                  op_done,
  output logic                  prog_fail,
  output logic                  cmd_err
);

  typedef enum logic [3:0] {
    INIT_SETUP = 4'd0,  INIT_STB = 4'd1,  INIT_HOLD = 4'd2,  IDLE    = 4'd3,
    RD_SETUP   = 4'd4,  RD_STB   = 4'd5,  RD_HOLD   = 4'd6,
    PG_SETUP   = 4'd7,  PG_STB   = 4'd8,  PG_HOLD   = 4'd9,
    VF_SETUP   = 4'd10, VF_STB   = 4'd11, VF_HOLD   = 4'd12
  } state_t;

  state_t                state_r, state_s;
  logic [7:0]            cnt_r;
  logic [6:0]            addr_r;
  logic [EFUSE_BITS-1:0] data_r;
  logic                  samp_r, done_r, op_done_r, prog_fail_r, cmd_err_r;
  logic                  rden_r, pgm_r, rd_r, wr_r;
  logic                  setup_end_s, rd_end_s, pg_end_s, last_bit_s;
  logic                  accept_s, reject_s, busy_err_s, rd_sample_s;

  // Phase-end decodes; cnt_r restarts at zero on every state change.
  assign setup_end_s = (cnt_r == 8'(SETUP_CYC - 1));
  assign rd_end_s    = (cnt_r == 8'(RD_STB_CYC - 1));
  assign pg_end_s    = (cnt_r == 8'(PG_STB_CYC - 1));
  assign last_bit_s  = (addr_r == 7'(EFUSE_BITS - 1));
  assign rd_sample_s = (state_r inside {INIT_STB, RD_STB, VF_STB}) && rd_end_s;
  // Commands are only refused as busy once the auto-load has finished.
  assign busy_err_s  = cmd_vld && done_r && (state_r != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= INIT_SETUP;
    else     state_r <= state_s;
  end

  // Next-state logic and command acceptance/rejection decode.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    reject_s = 1'b0;
    case (state_r)
      INIT_SETUP: if (setup_end_s) state_s = INIT_STB;  else state_s = state_r;
      INIT_STB:   if (rd_end_s)    state_s = INIT_HOLD; else state_s = state_r;
      INIT_HOLD:  if (last_bit_s)  state_s = IDLE;      else state_s = INIT_SETUP;
      IDLE: begin
        if (cmd_vld && done_r) begin
          if (!cmd_mode) begin
            state_s  = RD_SETUP;
            accept_s = 1'b1;
          end else if (pgm_en && !data_r[LOCK_BIT]) begin
            state_s  = PG_SETUP;
            accept_s = 1'b1;
          end else begin
            reject_s = 1'b1;
          end
        end else begin
          state_s = state_r;
        end
      end
      RD_SETUP: if (setup_end_s) state_s = RD_STB;   else state_s = state_r;
      RD_STB:   if (rd_end_s)    state_s = RD_HOLD;  else state_s = state_r;
      RD_HOLD:  state_s = IDLE;
      PG_SETUP: if (setup_end_s) state_s = PG_STB;   else state_s = state_r;
      PG_STB:   if (pg_end_s)    state_s = PG_HOLD;  else state_s = state_r;
      PG_HOLD:  state_s = VF_SETUP;
      VF_SETUP: if (setup_end_s) state_s = VF_STB;   else state_s = state_r;
      VF_STB:   if (rd_end_s)    state_s = VF_HOLD;  else state_s = state_r;
      VF_HOLD:  state_s = IDLE;
      default:  state_s = INIT_SETUP;
    endcase
  end

  // Phase counter, access address (doubles as the load index) and shadow data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= 8'd0;
      addr_r <= 7'd0;
      data_r <= '0;
      samp_r <= 1'b0;
    end else begin
      if (state_s != state_r) cnt_r <= 8'd0;
      else                    cnt_r <= cnt_r + 8'd1;
      if (accept_s)                                addr_r <= cmd_addr;
      else if ((state_r == INIT_HOLD) && !last_bit_s) addr_r <= addr_r + 7'd1;
      else                                         addr_r <= addr_r;
      if (rd_sample_s) begin
        data_r[addr_r] <= efuse_rdata;
        samp_r         <= efuse_rdata;
      end else begin
        samp_r         <= samp_r;
      end
    end
  end

  // Status flags; a completion beats a same-cycle op_done_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_r      <= 1'b0;
      op_done_r   <= 1'b0;
      prog_fail_r <= 1'b0;
      cmd_err_r   <= 1'b0;
    end else begin
      if ((state_r == INIT_HOLD) && last_bit_s) done_r <= 1'b1;
      else                                      done_r <= done_r;
      if ((state_r == RD_HOLD) || (state_r == VF_HOLD)) op_done_r <= 1'b1;
      else if (accept_s || op_done_clr)                 op_done_r <= 1'b0;
      else                                              op_done_r <= op_done_r;
      if (state_r == VF_HOLD) prog_fail_r <= prog_fail_r | ~samp_r;
      else if (accept_s)      prog_fail_r <= 1'b0;
      else                    prog_fail_r <= prog_fail_r;
      cmd_err_r <= reject_s || busy_err_s;
    end
  end

  // Strobes and busy flags registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rden_r <= 1'b0;
      pgm_r  <= 1'b0;
      rd_r   <= 1'b0;
      wr_r   <= 1'b0;
    end else begin
      rden_r <= state_s inside {INIT_STB, RD_STB, VF_STB};
      pgm_r  <= (state_s == PG_STB);
      rd_r   <= state_s inside {INIT_SETUP, INIT_STB, INIT_HOLD, RD_SETUP, RD_STB,
                                RD_HOLD, VF_SETUP, VF_STB, VF_HOLD};
      wr_r   <= state_s inside {PG_SETUP, PG_STB, PG_HOLD};
    end
  end

  assign efuse_addr = addr_r;
  assign efuse_rden = rden_r;
  assign efuse_pgm  = pgm_r;
  assign efuse_data = data_r;
  assign efuse_done = done_r;
  assign efuse_rd   = rd_r;
  assign efuse_wr   = wr_r;
  assign op_done    = op_done_r;
  assign prog_fail  = prog_fail_r;
  assign cmd_err    = cmd_err_r;

endmodule
